// File: rtl/ldpc_loopback_sequencer_if.sv
// ----------------------------------------------------------------------------
// ldpc_loopback_sequencer_if
// Bundles the configuration, encoder, decoder and statistics signals of the
// LDPC loopback sequencer.
//   master : sequencer side (drives message, mask, start_dec, status, counters)
//   slave  : environment side (CSR block, encoder, decoder)
// Signals:
//   cfg_start, cfg_abort, cfg_num_frames, cfg_seed, cfg_err_mask,
//   cfg_err_rotate, cfg_timeout              - run configuration
//   y_nr_in_port, valid_cword_enc            - encoder message / codeword valid
//   err_intro_q0_1, start_dec,
//   converged_loops_ended, pass_fail_decoder - decoder control / result
//   busy, done, frame_cnt, pass_cnt,
//   fail_cnt, timeout_cnt                    - run status and statistics
// ----------------------------------------------------------------------------
interface ldpc_loopback_sequencer_if #(
    parameter int NN    = 208,
    parameter int MM    = 168,
    parameter int CNT_W = 16
);
    localparam int K = NN - MM;

    logic             cfg_start;
    logic             cfg_abort;
    logic [CNT_W-1:0] cfg_num_frames;
    logic [K-1:0]     cfg_seed;
    logic [NN-1:0]    cfg_err_mask;
    logic             cfg_err_rotate;
    logic [CNT_W-1:0] cfg_timeout;

    logic [K-1:0]     y_nr_in_port;
    logic             valid_cword_enc;
    logic [NN-1:0]    err_intro_q0_1;
    logic             start_dec;
    logic             converged_loops_ended;
    logic             pass_fail_decoder;

    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] timeout_cnt;

    modport master (
        input  cfg_start, cfg_abort, cfg_num_frames, cfg_seed, cfg_err_mask,
               cfg_err_rotate, cfg_timeout,
        input  valid_cword_enc, converged_loops_ended, pass_fail_decoder,
        output y_nr_in_port, err_intro_q0_1, start_dec,
        output busy, done, frame_cnt, pass_cnt, fail_cnt, timeout_cnt
    );

    modport slave (
        output cfg_start, cfg_abort, cfg_num_frames, cfg_seed, cfg_err_mask,
               cfg_err_rotate, cfg_timeout,
        output valid_cword_enc, converged_loops_ended, pass_fail_decoder,
        input  y_nr_in_port, err_intro_q0_1, start_dec,
        input  busy, done, frame_cnt, pass_cnt, fail_cnt, timeout_cnt
    );
endinterface

// File: rtl/ldpc_loopback_sequencer.sv
// ----------------------------------------------------------------------------
// ldpc_loopback_sequencer
// Drives the on-chip LDPC encoder->decoder loopback: feeds LFSR message words
// to the encoder, waits for the codeword, applies the error-injection mask,
// pulses decoder start, waits for convergence and tallies pass/fail/timeout
// per frame for a programmed number of frames.
// Ports:
//   wb_clk_i : clock (rising edge)
//   wb_rst_i : asynchronous active-high reset
//   bus      : ldpc_loopback_sequencer_if.master (config, encoder, decoder,
//              status and counters)
// ----------------------------------------------------------------------------
module ldpc_loopback_sequencer #(
    parameter int              NN         = 208,
    parameter int              MM         = 168,
    parameter int              CNT_W      = 16,
    parameter int              ENC_SETTLE = 2,
    parameter logic [NN-MM-1:0] LFSR_TAPS = 40'hA0_0028_0000
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    ldpc_loopback_sequencer_if.master    bus
);
    localparam int K  = NN - MM;
    localparam int SW = $clog2(ENC_SETTLE + 2);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ENC_WAIT  = 3'd1;
    localparam logic [2:0] S_DEC_START = 3'd2;
    localparam logic [2:0] S_DEC_WAIT  = 3'd3;
    localparam logic [2:0] S_TALLY     = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]       state_q,   state_d;
    logic [K-1:0]     lfsr_q,    lfsr_d;
    logic [NN-1:0]    mask_q,    mask_d;
    logic [K-1:0]     y_q,       y_d;
    logic [NN-1:0]    err_q,     err_d;
    logic             start_q,   start_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [CNT_W-1:0] frame_q,   frame_d;
    logic [CNT_W-1:0] pass_q,    pass_d;
    logic [CNT_W-1:0] fail_q,    fail_d;
    logic [CNT_W-1:0] tmo_q,     tmo_d;
    logic [SW-1:0]    settle_q,  settle_d;
    logic [CNT_W-1:0] wait_q,    wait_d;

    logic [K-1:0]     seed_fix;
    logic [K-1:0]     lfsr_next;
    logic [CNT_W:0]   wait_inc;
    logic             timeout_hit;
    logic             last_frame;
    logic             settled;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign seed_fix  = (bus.cfg_seed == '0) ? {{(K-1){1'b0}}, 1'b1} : bus.cfg_seed;
    assign lfsr_next = {lfsr_q[K-2:0], ^(lfsr_q & LFSR_TAPS)};

    // Timeout fires in the cycle that would bring the wait counter up to
    // cfg_timeout, so the phase lasts exactly cfg_timeout cycles.
    assign wait_inc    = {1'b0, wait_q} + {{CNT_W{1'b0}}, 1'b1};
    assign timeout_hit = (bus.cfg_timeout != '0) && (wait_inc == {1'b0, bus.cfg_timeout});
    assign last_frame  = (({1'b0, frame_q} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, bus.cfg_num_frames});
    assign settled     = (settle_q == SW'(ENC_SETTLE));

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        mask_d   = mask_q;
        y_d      = y_q;
        err_d    = err_q;
        start_d  = 1'b0;
        busy_d   = busy_q;
        done_d   = done_q;
        frame_d  = frame_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        tmo_d    = tmo_q;
        settle_d = settle_q;
        wait_d   = wait_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cfg_start) begin
                    lfsr_d  = seed_fix;
                    mask_d  = bus.cfg_err_mask;
                    frame_d = '0;
                    pass_d  = '0;
                    fail_d  = '0;
                    tmo_d   = '0;
                    if (bus.cfg_num_frames == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d  = S_ENC_WAIT;
                        done_d   = 1'b0;
                        busy_d   = 1'b1;
                        y_d      = seed_fix;
                        settle_d = '0;
                        wait_d   = '0;
                    end
                end
            end
            S_ENC_WAIT: begin
                wait_d = wait_inc[CNT_W-1:0];
                if (!settled)
                    settle_d = settle_q + 1'b1;
                // A valid codeword wins over a timeout hitting the same cycle.
                if (settled && bus.valid_cword_enc) begin
                    state_d = S_DEC_START;
                    start_d = 1'b1;
                    err_d   = mask_q;
                end else if (timeout_hit) begin
                    tmo_d   = sat_inc(tmo_q);
                    state_d = S_TALLY;
                end
            end
            S_DEC_START: begin
                state_d = S_DEC_WAIT;
                wait_d  = '0;
            end
            S_DEC_WAIT: begin
                wait_d = wait_inc[CNT_W-1:0];
                if (bus.converged_loops_ended) begin
                    if (bus.pass_fail_decoder)
                        pass_d = sat_inc(pass_q);
                    else
                        fail_d = sat_inc(fail_q);
                    state_d = S_TALLY;
                end else if (timeout_hit) begin
                    tmo_d   = sat_inc(tmo_q);
                    state_d = S_TALLY;
                end
            end
            S_TALLY: begin
                frame_d = sat_inc(frame_q);
                lfsr_d  = lfsr_next;
                err_d   = '0;
                if (bus.cfg_err_rotate)
                    mask_d = {mask_q[NN-2:0], mask_q[NN-1]};
                if (last_frame) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d  = S_ENC_WAIT;
                    y_d      = lfsr_next;
                    settle_d = '0;
                    wait_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything above: drop the run, keep statistics.
        if (bus.cfg_abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            start_d = 1'b0;
            err_d   = '0;
            done_d  = done_q;
            lfsr_d  = lfsr_q;
            mask_d  = mask_q;
            y_d     = y_q;
            frame_d = frame_q;
            pass_d  = pass_q;
            fail_d  = fail_q;
            tmo_d   = tmo_q;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            lfsr_q   <= {{(K-1){1'b0}}, 1'b1};
            mask_q   <= '0;
            y_q      <= '0;
            err_q    <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            frame_q  <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
            tmo_q    <= '0;
            settle_q <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            mask_q   <= mask_d;
            y_q      <= y_d;
            err_q    <= err_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            frame_q  <= frame_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            tmo_q    <= tmo_d;
            settle_q <= settle_d;
            wait_q   <= wait_d;
        end
    end

    assign bus.y_nr_in_port   = y_q;
    assign bus.err_intro_q0_1 = err_q;
    assign bus.start_dec      = start_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.frame_cnt      = frame_q;
    assign bus.pass_cnt       = pass_q;
    assign bus.fail_cnt       = fail_q;
    assign bus.timeout_cnt    = tmo_q;

endmodule
